// File: rtl/cpu_pkg.sv
// Shared CPU constants and the write-back requester encoding.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LD  = 1;

    typedef enum logic {
        PtrAlu = 1'b0,
        PtrLd  = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on contention.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    rr_ptr_e ptr_q, ptr_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= PtrAlu;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Only a contested cycle moves the pointer, always to the loser.
    always_comb begin
        ptr_d = ptr_q;
        if (req[REQ_ALU] && req[REQ_LD]) begin
            ptr_d = (ptr_q == PtrAlu) ? PtrLd : PtrAlu;
        end
    end

    always_comb begin
        gnt = 2'b00;
        if (req[REQ_ALU] && req[REQ_LD]) begin
            if (ptr_q == PtrAlu) begin
                gnt[REQ_ALU] = 1'b1;
            end else begin
                gnt[REQ_LD] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load unit and tracks
// pending destination registers for decode-stage stalls.
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W   = cpu_pkg::DATA_W,
    parameter int unsigned ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned NUM_REGS = 2 ** ADDR_W
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [ADDR_W-1:0]   ld_rd,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                issue_valid,
    input  logic [ADDR_W-1:0]   issue_rd,
    input  logic [ADDR_W-1:0]   rs1,
    input  logic [ADDR_W-1:0]   rs2,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic                we,
    output logic [ADDR_W-1:0]   rd,
    output logic [DATA_W-1:0]   din,
    output logic [NUM_REGS-1:0] pending,
    output logic                wb_err
);

    logic [1:0]          req, gnt;
    logic                accept, wr_en;
    logic [ADDR_W-1:0]   sel_rd;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] set_mask, clr_mask;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                we_q, wb_err_q, wb_err_d;
    logic [ADDR_W-1:0]   rd_q;
    logic [DATA_W-1:0]   din_q;

    always_comb begin
        req          = 2'b00;
        req[REQ_ALU] = alu_valid;
        req[REQ_LD]  = ld_valid;
    end

    rr_arb2 u_rr_arb2 (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .gnt     (gnt)
    );

    // Readies are forced low while reset is held so nothing is consumed.
    always_comb begin
        alu_ready = gnt[REQ_ALU] & reset_n;
        ld_ready  = gnt[REQ_LD] & reset_n;
        accept    = alu_ready | ld_ready;
        sel_rd    = ld_ready ? ld_rd : alu_rd;
        sel_data  = ld_ready ? ld_data : alu_data;
        wr_en     = accept && (sel_rd != '0);
    end

    // Set is applied after clear so a re-issued destination stays reserved.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && (issue_rd != '0)) begin
            set_mask = {{(NUM_REGS-1){1'b0}}, 1'b1} << issue_rd;
        end
        if (wr_en) begin
            clr_mask = {{(NUM_REGS-1){1'b0}}, 1'b1} << sel_rd;
        end
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
        wb_err_d     = wb_err_q | (wr_en && !pending_q[sel_rd]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we_q      <= 1'b0;
            rd_q      <= '0;
            din_q     <= '0;
            pending_q <= '0;
            wb_err_q  <= 1'b0;
        end else begin
            we_q      <= wr_en;
            pending_q <= pending_d;
            wb_err_q  <= wb_err_d;
            if (wr_en) begin
                rd_q  <= sel_rd;
                din_q <= sel_data;
            end
        end
    end

    always_comb begin
        we       = we_q;
        rd       = rd_q;
        din      = din_q;
        pending  = pending_q;
        wb_err   = wb_err_q;
        rs1_busy = pending_q[rs1];
        rs2_busy = pending_q[rs2];
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized self-checking bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid, ld_valid, issue_valid;
    logic        alu_ready, ld_ready;
    logic [4:0]  alu_rd, ld_rd, issue_rd, rs1, rs2, rd;
    logic [31:0] alu_data, ld_data, din, pending;
    logic        rs1_busy, rs2_busy, we, wb_err;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state: who wins a tie, the last write, the scoreboard, the error flag.
    int          m_favour;
    bit          m_we, m_err;
    bit [4:0]    m_rd;
    bit [31:0]   m_din, m_pend;
    bit          m_alu_won, m_ld_won;

    always #5 clock = ~clock;

    regfile_wb_arbiter dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_rd       (ld_rd),
        .ld_data     (ld_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .we          (we),
        .rd          (rd),
        .din         (din),
        .pending     (pending),
        .wb_err      (wb_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_favour  = 0;
        m_we      = 0;
        m_err     = 0;
        m_rd      = 0;
        m_din     = 0;
        m_pend    = 0;
        m_alu_won = 0;
        m_ld_won  = 0;
    endtask

    task automatic set_in(input bit av, input bit [4:0] ar, input bit [31:0] ad,
                          input bit lv, input bit [4:0] lr, input bit [31:0] ldv,
                          input bit iv, input bit [4:0] ir);
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid = lv;  ld_rd = lr;  ld_data = ldv;
        issue_valid = iv; issue_rd = ir;
        rs1 = 5'($urandom); rs2 = 5'($urandom);
    endtask

    // Called just after a falling edge with inputs driven; returns after the next falling edge.
    task automatic step();
        int          winner;
        bit          any;
        bit [4:0]    wrd;
        bit [31:0]   wdat;
        #1;
        any = alu_valid | ld_valid;
        if (alu_valid && ld_valid) winner = m_favour;
        else if (alu_valid)        winner = 0;
        else                       winner = 1;
        check_eq("alu_ready", alu_ready, any && winner == 0);
        check_eq("ld_ready",  ld_ready,  any && winner == 1);
        check_eq("we",        we,        m_we);
        check_eq("rd",        rd,        m_rd);
        check_eq("din",       din,       m_din);
        check_eq("pending",   pending,   m_pend);
        check_eq("wb_err",    wb_err,    m_err);
        check_eq("rs1_busy",  rs1_busy,  m_pend[rs1]);
        check_eq("rs2_busy",  rs2_busy,  m_pend[rs2]);
        m_alu_won = any && winner == 0;
        m_ld_won  = any && winner == 1;
        @(posedge clock);
        if (alu_valid && ld_valid) m_favour = 1 - winner;
        wrd  = (winner == 0) ? alu_rd : ld_rd;
        wdat = (winner == 0) ? alu_data : ld_data;
        m_we = any && wrd != 0;
        if (m_we) begin
            m_rd  = wrd;
            m_din = wdat;
            if (!m_pend[wrd]) m_err = 1;
            m_pend[wrd] = 0;
        end
        if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1;
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        check_eq("rst_we", we, 0);
        check_eq("rst_pending", pending, 0);
        check_eq("rst_wb_err", wb_err, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Single ALU write to a reserved register.
        set_in(0, 0, 0, 0, 0, 0, 1, 3);                    step();
        set_in(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);         step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);                    step();
        check_eq("single_din", din, 32'hDEADBEEF);

        // Contention: reserve 5 and 6 repeatedly so every write is legitimate.
        set_in(0, 0, 0, 0, 0, 0, 1, 5);                    step();
        set_in(0, 0, 0, 0, 0, 0, 1, 6);                    step();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 5, 32'hA000 + i, 1, 6, 32'hB000 + i, 1, (i % 2 == 0) ? 5'd5 : 5'd6);
            step();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0);                    step();

        // Register 0 writes and reservations are ignored.
        set_in(0, 0, 0, 1, 0, 32'h1, 1, 0);                step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);                    step();

        // Set/clear collision on register 7.
        set_in(0, 0, 0, 0, 0, 0, 1, 7);                    step();
        set_in(1, 7, 32'h77, 0, 0, 0, 1, 7);               step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0); rs1 = 7;           step();
        check_eq("collide_busy", rs1_busy, 1);

        // Spurious write to non-pending register 9.
        set_in(1, 9, 32'h99, 0, 0, 0, 0, 0);               step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);                    step();
        check_eq("spurious_err", wb_err, 1);

        // Randomized traffic honouring the hold-while-not-granted rule.
        for (int c = 0; c < 400; c++) begin
            if (!(alu_valid && !m_alu_won)) begin
                alu_valid = ($urandom % 3) != 0;
                alu_rd    = 5'($urandom);
                alu_data  = $urandom;
            end
            if (!(ld_valid && !m_ld_won)) begin
                ld_valid = ($urandom % 3) != 0;
                ld_rd    = 5'($urandom);
                ld_data  = $urandom;
            end
            issue_valid = $urandom % 2;
            issue_rd    = 5'($urandom);
            rs1 = 5'($urandom);
            rs2 = 5'($urandom);
            step();
        end

        // Asynchronous reset while a write is on the port.
        set_in(0, 0, 0, 0, 0, 0, 1, 12);                   step();
        set_in(1, 12, 32'hC0FFEE, 0, 0, 0, 1, 13);         step();
        check_eq("pre_rst_we", we, 1);
        set_in(1, 14, 32'h5, 0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst_we", we, 0);
        check_eq("midrst_pending", pending, 0);
        check_eq("midrst_wb_err", wb_err, 0);
        check_eq("midrst_alu_ready", alu_ready, 0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);                    step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
